eh2_dec_gpr_mt_ctl: RTL and testbench
=====================================

// Module: eh2_dec_gpr_mt_ctl
// PURPOSE
//  Parametrised multi-thread GPR file for the decode stage. It provides NUM_THREADS banks of 31 x XLEN registers,
//  with NUM_RPORTS read ports and NUM_WPORTS write ports. Additions: per-register load-busy scoreboard, optional
//  write->read bypass, deterministic write-port priority with collision flag, and a sequential per-thread clear
//  engine used on thread reset/flush. Sits between decode (reads/scoreboard) and writeback/LSU (writes).
// PARAMETERS
//  NUM_THREADS  2   hardware threads (banks); TW = (NUM_THREADS>1) ? $clog2(NUM_THREADS) : 1
//  NUM_RPORTS   4   read ports
//  NUM_WPORTS   4   write ports; higher index = younger
//  XLEN         32  register width
//  BYPASS       1   1: same-cycle write data forwarded to matching reads; 0: writes visible next cycle
// PORTS
//  clk          in   1              clock
//  rst_l        in   1              async reset, active low
//  scan_mode    in   1              scan enable, passed to flops
//  rden         in   NUM_RPORTS     read enables
//  rtid         in   NUM_RPORTS*TW  read thread ids
//  raddr        in   NUM_RPORTS*5   read addresses
//  rd           out  NUM_RPORTS*XLEN read data (combinational)
//  rd_busy      out  NUM_RPORTS     scoreboard busy of addressed register (combinational)
//  wen          in   NUM_WPORTS     write enables
//  wtid         in   NUM_WPORTS*TW  write thread ids
//  waddr        in   NUM_WPORTS*5   write addresses
//  wd           in   NUM_WPORTS*XLEN write data
//  sb_set       in   1              mark register busy (load issued)
//  sb_tid       in   TW             thread for sb_set
//  sb_addr      in   5              register for sb_set
//  clr_req      in   1              start clear of one thread bank
//  clr_tid      in   TW             thread to clear
//  clr_busy     out  1              clear engine active
//  clr_done     out  1              one-cycle pulse, clear finished
//  wr_collision out  1              registered: >=2 enabled ports hit same tid/addr last cycle
// BEHAVIOUR
//  - Reset (rst_l=0, async): all registers 0, all busy bits 0, FSM=IDLE, clr_busy=0, clr_done=0, wr_collision=0.
//  - x0: reads return 0 and rd_busy=0. Writes, sb_set and clear never target x0.
//  - Read: rd[p] = rden[p] ? reg[rtid][raddr] : 0. If rden=0, rd_busy[p]=0.
//  - Write: a port with wen=1 and waddr!=0 updates reg[wtid][waddr] at the next clk edge.
//    If several ports hit the same tid/addr, the highest-index port wins.
//    wr_collision is set to 1 the following cycle for one cycle per colliding cycle.
//  - Bypass (BYPASS=1): rd[p] returns the winning same-cycle write data for a matching tid/addr.
//    rd_busy[p] is 0 when a same-cycle write clears that register.
//  - Scoreboard: sb_set sets busy[sb_tid][sb_addr] at the next edge. Any accepted write clears busy for that register.
//    If set and clear hit the same register in the same cycle, set wins (busy=1).
//  - Clear FSM: IDLE --clr_req--> CLEAR(cnt=1, tid latched) --cnt==31--> DONE --> IDLE.
//    CLEAR: one register per cycle, reg[tid][cnt]=0 and busy=0, cnt++. Takes 31 cycles.
//    DONE: clr_done=1 for 1 cycle. clr_busy=1 in CLEAR and DONE.
//  - During CLEAR/DONE: writes and sb_set to the latched tid are dropped and do not count for wr_collision.
//    Other threads operate normally. Reads of the latched tid return current contents.
//  - clr_req while clr_busy=1 is ignored. clr_req in the cycle clr_done=1 is ignored. Requester retries in IDLE.
//  - Async reset mid-clear aborts immediately to the reset state.
// TESTING
//  1 Reset, then write port0 t0 x5=0xDEADBEEF; next cycle read port2 t0 x5 -> 0xDEADBEEF; t1 x5 -> 0.
//  2 Same cycle: wen0 t1 x7=0x11, wen3 t1 x7=0x33 -> x7=0x33; wr_collision=1 exactly one cycle later.
//  3 BYPASS=1: write t0 x9=0xA5A5A5A5 and read t0 x9 in same cycle -> rd=0xA5A5A5A5. BYPASS=0 -> old value.
//  4 sb_set t0 x3 -> rd_busy=1 next cycle. Write t0 x3 -> busy 0. Set and write same cycle -> busy stays 1.
//  5 Fill t1 x1..x31; clr_req t1 -> clr_busy 32 cycles, clr_done pulse at cycle 32. All t1 regs 0, t0 unchanged.
//    A t1 write mid-clear is dropped.
//  6 Assert rst_l low at clear cycle 10 -> clr_busy=0 immediately, all regs 0. A new clr_req after reset restarts at x1.

Source files
------------

// File: rtl/eh2_dec_gpr_mt_ctl.sv
// Multi-thread decode-stage GPR file: banked registers, load-busy scoreboard,
// optional write->read bypass, write collision flag and a per-thread clear engine.
module eh2_dec_gpr_mt_ctl #(
  parameter  int NUM_THREADS = 2,
  parameter  int NUM_RPORTS  = 4,
  parameter  int NUM_WPORTS  = 4,
  parameter  int XLEN        = 32,
  parameter  int BYPASS      = 1,
  localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       scan_mode,
  input  logic [NUM_RPORTS-1:0]      rden,
  input  logic [NUM_RPORTS*TW-1:0]   rtid,
  input  logic [NUM_RPORTS*5-1:0]    raddr,
  output logic [NUM_RPORTS*XLEN-1:0] rd,
  output logic [NUM_RPORTS-1:0]      rd_busy,
  input  logic [NUM_WPORTS-1:0]      wen,
  input  logic [NUM_WPORTS*TW-1:0]   wtid,
  input  logic [NUM_WPORTS*5-1:0]    waddr,
  input  logic [NUM_WPORTS*XLEN-1:0] wd,
  input  logic                       sb_set,
  input  logic [TW-1:0]              sb_tid,
  input  logic [4:0]                 sb_addr,
  input  logic                       clr_req,
  input  logic [TW-1:0]              clr_tid,
  output logic                       clr_busy,
  output logic                       clr_done,
  output logic                       wr_collision
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [TW-1:0]         ctid_q, ctid_d;
  logic                  coll_q, coll_d;
  logic [XLEN-1:0]       mem_q  [NUM_THREADS][32];
  logic [XLEN-1:0]       mem_d  [NUM_THREADS][32];
  logic [31:0]           busy_q [NUM_THREADS];
  logic [31:0]           busy_d [NUM_THREADS];
  logic [NUM_WPORTS-1:0] wacc;
  logic                  clr_act;
  logic                  unused_scan;

  // Flops are not clock-gated here, so scan_mode has no functional use.
  assign unused_scan  = scan_mode;
  assign clr_act      = (state_q != IDLE);
  assign clr_busy     = clr_act;
  assign clr_done     = (state_q == DONE);
  assign wr_collision = coll_q;

  // Writes to x0 or to the bank being cleared are dropped entirely.
  always_comb begin
    wacc = '0;
    for (int w = 0; w < NUM_WPORTS; w++) begin
      wacc[w] = wen[w] && (waddr[w*5 +: 5] != 5'd0) &&
                !(clr_act && (wtid[w*TW +: TW] == ctid_q));
    end
  end

  always_comb begin
    coll_d = 1'b0;
    for (int i = 0; i < NUM_WPORTS; i++) begin
      for (int j = i + 1; j < NUM_WPORTS; j++) begin
        if (wacc[i] && wacc[j] && (wtid[i*TW +: TW] == wtid[j*TW +: TW]) &&
            (waddr[i*5 +: 5] == waddr[j*5 +: 5])) begin
          coll_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctid_d  = ctid_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = 5'd1;
          ctid_d  = clr_tid;
        end
      end
      CLEAR: begin
        if (cnt_q == 5'd31) state_d = DONE;
        else                cnt_d   = cnt_q + 5'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Later ports overwrite earlier ones, so the highest-index port wins; sb_set comes last so it beats a clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WPORTS; w++) begin
      if (wacc[w]) begin
        mem_d[wtid[w*TW +: TW]][waddr[w*5 +: 5]]  = wd[w*XLEN +: XLEN];
        busy_d[wtid[w*TW +: TW]][waddr[w*5 +: 5]] = 1'b0;
      end
    end
    if (state_q == CLEAR) begin
      mem_d[ctid_q][cnt_q]  = '0;
      busy_d[ctid_q][cnt_q] = 1'b0;
    end
    if (sb_set && (sb_addr != 5'd0) && !(clr_act && (sb_tid == ctid_q))) begin
      busy_d[sb_tid][sb_addr] = 1'b1;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      if (rden[p] && (raddr[p*5 +: 5] != 5'd0)) begin
        rd[p*XLEN +: XLEN] = mem_q[rtid[p*TW +: TW]][raddr[p*5 +: 5]];
        rd_busy[p]         = busy_q[rtid[p*TW +: TW]][raddr[p*5 +: 5]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WPORTS; w++) begin
            if (wacc[w] && (wtid[w*TW +: TW] == rtid[p*TW +: TW]) &&
                (waddr[w*5 +: 5] == raddr[p*5 +: 5])) begin
              rd[p*XLEN +: XLEN] = wd[w*XLEN +: XLEN];
              rd_busy[p]         = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctid_q  <= '0;
      coll_q  <= 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        busy_q[t] <= '0;
        for (int a = 0; a < 32; a++) begin
          mem_q[t][a] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctid_q  <= ctid_d;
      coll_q  <= coll_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_eh2_dec_gpr_mt_ctl.sv
// Bench for eh2_dec_gpr_mt_ctl: directed scenarios plus random traffic, compared each
// cycle against a register-array model; a BYPASS=0 copy shares the same stimulus.
module tb_eh2_dec_gpr_mt_ctl;

  localparam int NR = 4;
  localparam int NW = 4;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic scan_mode = 1'b0;
  logic [NR-1:0]    rden;
  logic [NR-1:0]    rtid;
  logic [NR*5-1:0]  raddr;
  logic [NR*XL-1:0] rd_b, rd_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic [NW-1:0]    wen;
  logic [NW-1:0]    wtid;
  logic [NW*5-1:0]  waddr;
  logic [NW*XL-1:0] wd;
  logic             sb_set;
  logic [0:0]       sb_tid;
  logic [4:0]       sb_addr;
  logic             clr_req;
  logic [0:0]       clr_tid;
  logic clr_busy_b, clr_done_b, coll_b;
  logic clr_busy_n, clr_done_n, coll_n;

  int checks = 0;
  int failures = 0;

  // Reference state: plain arrays plus a countdown for the clear engine
  // (32 = first clear cycle, 2 = clearing x31, 1 = done pulse, 0 = idle).
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_timer;
  bit          m_clr_tid;
  bit          m_coll;

  int busy_cycles;
  int done_at;

  always #5 clk = ~clk;

  eh2_dec_gpr_mt_ctl #(.BYPASS(1)) dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode),
    .rden(rden), .rtid(rtid), .raddr(raddr), .rd(rd_b), .rd_busy(rd_busy_b),
    .wen(wen), .wtid(wtid), .waddr(waddr), .wd(wd),
    .sb_set(sb_set), .sb_tid(sb_tid), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_tid(clr_tid), .clr_busy(clr_busy_b),
    .clr_done(clr_done_b), .wr_collision(coll_b)
  );

  eh2_dec_gpr_mt_ctl #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode),
    .rden(rden), .rtid(rtid), .raddr(raddr), .rd(rd_n), .rd_busy(rd_busy_n),
    .wen(wen), .wtid(wtid), .waddr(waddr), .wd(wd),
    .sb_set(sb_set), .sb_tid(sb_tid), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_tid(clr_tid), .clr_busy(clr_busy_n),
    .clr_done(clr_done_n), .wr_collision(coll_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < 32; a++) begin
        m_mem[t][a]  = '0;
        m_busy[t][a] = 1'b0;
      end
    end
    m_timer   = 0;
    m_clr_tid = 1'b0;
    m_coll    = 1'b0;
  endtask

  function automatic bit acc(input int w);
    return wen[w] && (waddr[w*5 +: 5] != 5'd0) && !((m_timer > 0) && (wtid[w] == m_clr_tid));
  endfunction

  task automatic model_update();
    int hits [2][32];
    bit new_coll;
    int idx;
    new_coll = 1'b0;
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 32; a++) hits[t][a] = 0;
    for (int w = 0; w < NW; w++)
      if (acc(w)) hits[wtid[w]][waddr[w*5 +: 5]]++;
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 32; a++)
        if (hits[t][a] >= 2) new_coll = 1'b1;
    for (int w = 0; w < NW; w++) begin
      if (acc(w)) begin
        m_mem[wtid[w]][waddr[w*5 +: 5]]  = wd[w*XL +: XL];
        m_busy[wtid[w]][waddr[w*5 +: 5]] = 1'b0;
      end
    end
    if (m_timer > 1) begin
      idx = 33 - m_timer;
      m_mem[m_clr_tid][idx]  = '0;
      m_busy[m_clr_tid][idx] = 1'b0;
    end
    if (sb_set && (sb_addr != 5'd0) && !((m_timer > 0) && (sb_tid[0] == m_clr_tid)))
      m_busy[sb_tid[0]][sb_addr] = 1'b1;
    if (m_timer > 0) begin
      m_timer--;
    end else if (clr_req) begin
      m_timer   = 32;
      m_clr_tid = clr_tid[0];
    end
    m_coll = new_coll;
  endtask

  task automatic checkOutput();
    logic [31:0] base, byp;
    logic [4:0]  a;
    bit          tid, bsy, hit;
    for (int p = 0; p < NR; p++) begin
      tid  = rtid[p];
      a    = raddr[p*5 +: 5];
      base = (rden[p] && a != 5'd0) ? m_mem[tid][a] : 32'h0;
      bsy  = rden[p] && (a != 5'd0) && m_busy[tid][a];
      byp  = base;
      hit  = 1'b0;
      for (int w = NW - 1; w >= 0; w--) begin
        if (!hit && rden[p] && acc(w) && (wtid[w] == tid) && (waddr[w*5 +: 5] == a)) begin
          byp = wd[w*XL +: XL];
          hit = 1'b1;
        end
      end
      chk($sformatf("rd_byp[%0d]", p), rd_b[p*XL +: XL], byp);
      chk($sformatf("rd_busy_byp[%0d]", p), {31'b0, rd_busy_b[p]}, {31'b0, bsy && !hit});
      chk($sformatf("rd_nobyp[%0d]", p), rd_n[p*XL +: XL], base);
      chk($sformatf("rd_busy_nobyp[%0d]", p), {31'b0, rd_busy_n[p]}, {31'b0, bsy});
    end
    chk("clr_busy", {31'b0, clr_busy_b}, {31'b0, m_timer > 0});
    chk("clr_done", {31'b0, clr_done_b}, {31'b0, m_timer == 1});
    chk("wr_collision", {31'b0, coll_b}, {31'b0, m_coll});
    chk("clr_busy_nb", {31'b0, clr_busy_n}, {31'b0, m_timer > 0});
    chk("clr_done_nb", {31'b0, clr_done_n}, {31'b0, m_timer == 1});
    chk("wr_collision_nb", {31'b0, coll_n}, {31'b0, m_coll});
  endtask

  task automatic idle_inputs();
    rden = '0; rtid = '0; raddr = '0;
    wen = '0; wtid = '0; waddr = '0; wd = '0;
    sb_set = 1'b0; sb_tid = '0; sb_addr = '0;
    clr_req = 1'b0; clr_tid = '0;
  endtask

  task automatic set_read(input int p, input int t, input int a);
    rden[p] = 1'b1;
    rtid[p] = t[0];
    raddr[p*5 +: 5] = a[4:0];
  endtask

  task automatic set_write(input int w, input int t, input int a, input logic [31:0] d);
    wen[w] = 1'b1;
    wtid[w] = t[0];
    waddr[w*5 +: 5] = a[4:0];
    wd[w*XL +: XL] = d;
  endtask

  task automatic applyStimulus();
    idle_inputs();
    for (int p = 0; p < NR; p++) begin
      rden[p] = ($urandom_range(0, 3) != 0);
      rtid[p] = 1'($urandom_range(0, 1));
      raddr[p*5 +: 5] = 5'($urandom_range(0, 7));
    end
    for (int w = 0; w < NW; w++) begin
      wen[w] = ($urandom_range(0, 2) == 0);
      wtid[w] = 1'($urandom_range(0, 1));
      waddr[w*5 +: 5] = 5'($urandom_range(0, 7));
      wd[w*XL +: XL] = $urandom;
    end
    sb_set  = ($urandom_range(0, 3) == 0);
    sb_tid  = 1'($urandom_range(0, 1));
    sb_addr = 5'($urandom_range(0, 7));
    clr_req = ($urandom_range(0, 40) == 0);
    clr_tid = 1'($urandom_range(0, 1));
  endtask

  // Inputs are set just after a falling edge; outputs are compared 1 ns later.
  task automatic run_cycle();
    #1;
    checkOutput();
    @(posedge clk);
    if (rst_l) model_update();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);

    // Reset state
    set_read(0, 0, 5);
    #1;
    chk("reset_clr_busy", {31'b0, clr_busy_b}, 32'h0);
    chk("reset_clr_done", {31'b0, clr_done_b}, 32'h0);
    chk("reset_wr_collision", {31'b0, coll_b}, 32'h0);
    chk("reset_rd", rd_b[31:0], 32'h0);
    run_cycle();
    run_cycle();
    rst_l = 1'b1;

    // Basic write then read, bank isolation
    idle_inputs();
    set_write(0, 0, 5, 32'hDEADBEEF);
    run_cycle();
    idle_inputs();
    set_read(2, 0, 5);
    set_read(1, 1, 5);
    #1;
    chk("t0_x5_read", rd_b[2*XL +: XL], 32'hDEADBEEF);
    chk("t1_x5_read", rd_b[1*XL +: XL], 32'h0);
    run_cycle();

    // Same-cycle collision, highest port wins
    idle_inputs();
    set_write(0, 1, 7, 32'h11);
    set_write(3, 1, 7, 32'h33);
    run_cycle();
    idle_inputs();
    set_read(0, 1, 7);
    #1;
    chk("collision_winner", rd_b[31:0], 32'h33);
    chk("collision_flag", {31'b0, coll_b}, 32'h1);
    run_cycle();
    idle_inputs();
    #1;
    chk("collision_flag_clears", {31'b0, coll_b}, 32'h0);
    run_cycle();

    // Bypass vs no bypass
    idle_inputs();
    set_write(1, 0, 9, 32'hA5A5A5A5);
    set_read(0, 0, 9);
    #1;
    chk("bypass_rd", rd_b[31:0], 32'hA5A5A5A5);
    chk("nobypass_rd", rd_n[31:0], 32'h0);
    run_cycle();

    // Scoreboard set, clear, set-wins
    idle_inputs();
    sb_set = 1'b1; sb_tid = 1'b0; sb_addr = 5'd3;
    run_cycle();
    idle_inputs();
    set_read(0, 0, 3);
    #1;
    chk("sb_busy_set", {31'b0, rd_busy_b[0]}, 32'h1);
    set_write(0, 0, 3, 32'h77);
    #1;
    chk("sb_busy_bypass_write", {31'b0, rd_busy_b[0]}, 32'h0);
    chk("sb_busy_nobypass_write", {31'b0, rd_busy_n[0]}, 32'h1);
    run_cycle();
    idle_inputs();
    set_read(0, 0, 3);
    #1;
    chk("sb_busy_cleared", {31'b0, rd_busy_b[0]}, 32'h0);
    set_write(2, 0, 3, 32'h78);
    sb_set = 1'b1; sb_tid = 1'b0; sb_addr = 5'd3;
    run_cycle();
    idle_inputs();
    set_read(0, 0, 3);
    #1;
    chk("sb_set_wins", {31'b0, rd_busy_b[0]}, 32'h1);
    run_cycle();

    // Fill t1, clear it, drop a mid-clear write
    for (int i = 1; i <= 31; i++) begin
      idle_inputs();
      set_write(i % NW, 1, i, 32'h1000 + i);
      run_cycle();
    end
    idle_inputs();
    clr_req = 1'b1; clr_tid = 1'b1;
    run_cycle();
    busy_cycles = 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      idle_inputs();
      if (c == 5) set_write(0, 1, 4, 32'h00000BAD);
      set_read(1, 1, 31);
      set_read(2, 0, 5);
      #1;
      if (clr_busy_b) busy_cycles++;
      if (clr_done_b) done_at = c;
      run_cycle();
    end
    chk("clear_busy_cycles", busy_cycles, 32);
    chk("clear_done_cycle", done_at, 32);
    idle_inputs();
    set_read(0, 1, 4);
    set_read(1, 1, 31);
    set_read(2, 0, 5);
    set_read(3, 1, 7);
    #1;
    chk("cleared_t1_x4", rd_b[0*XL +: XL], 32'h0);
    chk("cleared_t1_x31", rd_b[1*XL +: XL], 32'h0);
    chk("kept_t0_x5", rd_b[2*XL +: XL], 32'hDEADBEEF);
    chk("cleared_t1_x7", rd_b[3*XL +: XL], 32'h0);
    run_cycle();

    // Async reset mid-clear, then a fresh clear starts at x1
    idle_inputs();
    set_write(0, 1, 20, 32'h2020);
    set_write(1, 0, 31, 32'h3131);
    run_cycle();
    idle_inputs();
    clr_req = 1'b1; clr_tid = 1'b0;
    run_cycle();
    for (int c = 1; c <= 9; c++) begin
      idle_inputs();
      run_cycle();
    end
    idle_inputs();
    set_read(0, 1, 20);
    set_read(1, 0, 31);
    #1;
    chk("preclear_t0_x31", rd_b[1*XL +: XL], 32'h3131);
    chk("midclear_busy", {31'b0, clr_busy_b}, 32'h1);
    #2;
    rst_l = 1'b0;
    model_reset();
    #1;
    chk("abort_clr_busy", {31'b0, clr_busy_b}, 32'h0);
    chk("abort_t1_x20", rd_b[0*XL +: XL], 32'h0);
    chk("abort_t0_x31", rd_b[1*XL +: XL], 32'h0);
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    idle_inputs();
    set_write(0, 0, 1, 32'h111);
    set_write(1, 0, 2, 32'h222);
    run_cycle();
    idle_inputs();
    clr_req = 1'b1; clr_tid = 1'b0;
    run_cycle();
    idle_inputs();
    run_cycle();
    idle_inputs();
    set_read(0, 0, 1);
    set_read(1, 0, 2);
    #1;
    chk("restart_x1_cleared", rd_b[0*XL +: XL], 32'h0);
    chk("restart_x2_kept", rd_b[1*XL +: XL], 32'h222);
    run_cycle();
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      run_cycle();
    end

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      applyStimulus();
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
